// File: rtl/nibble_frame_rx.sv
// Nibble-stream frame receiver: finds the A/5 sync, assembles payload bytes, checks an
// 8-bit sum checksum, and releases only good frames on a byte-wide valid/ready master.
module nibble_frame_rx #(
    parameter int unsigned DEPTH = 32
) (
    input  logic        sys_clock,
    input  logic        sys_rst_n,
    input  logic [3:0]  idata,
    output logic [7:0]  m_tdata,
    output logic        m_tvalid,
    input  logic        m_tready,
    output logic        m_tlast,
    output logic        frame_ok,
    output logic        frame_err,
    output logic [1:0]  err_code,
    output logic [15:0] ok_cnt,
    output logic [15:0] err_cnt
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;
    localparam int unsigned CW = 5;

    typedef enum logic [2:0] {
        IDLE, SYNC, LEN, PAY_H, PAY_L, CK_H, CK_L
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [CW-1:0]   r_cnt;
    logic [3:0]      r_hi;
    logic [7:0]      r_sum;
    logic            r_ovf;
    logic [PW-1:0]   r_wr_ptr;
    logic [PW-1:0]   r_commit_ptr;
    logic [PW-1:0]   r_rd_ptr;
    logic            r_frame_ok;
    logic            r_frame_err;
    logic [1:0]      r_err_code;
    logic [15:0]     r_ok_cnt;
    logic [15:0]     r_err_cnt;
    logic [8:0]      r_mem [DEPTH];

    logic [7:0]      w_byte;
    logic            w_full;
    logic            w_wr_en;
    logic            w_last;
    logic            w_commit;
    logic            w_valid;
    logic            w_pop;
    logic [8:0]      w_rd_word;

    assign w_byte    = {r_hi, idata};
    assign w_full    = (r_wr_ptr - r_rd_ptr) == PW'(DEPTH);
    assign w_last    = (r_cnt == CW'(1));
    assign w_valid   = (r_rd_ptr != r_commit_ptr);
    assign w_pop     = w_valid && m_tready;
    assign w_rd_word = r_mem[r_rd_ptr[AW-1:0]];

    // Next-state and per-state strobes
    always_comb begin
        w_state_nxt = r_state;
        w_wr_en     = 1'b0;
        w_commit    = 1'b0;
        case (r_state)
            IDLE:    if (idata == 4'hA) w_state_nxt = SYNC;
            SYNC: begin
                if (idata == 4'h5)      w_state_nxt = LEN;
                else if (idata != 4'hA) w_state_nxt = IDLE;
            end
            LEN:     w_state_nxt = PAY_H;
            PAY_H:   w_state_nxt = PAY_L;
            PAY_L: begin
                w_wr_en     = !w_full;
                w_state_nxt = w_last ? CK_H : PAY_H;
            end
            CK_H:    w_state_nxt = CK_L;
            CK_L: begin
                w_commit    = (w_byte == r_sum) && !r_ovf;
                w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge sys_clock) begin
        if (!sys_rst_n) r_state <= IDLE;
        else            r_state <= w_state_nxt;
    end

    // Frame datapath, pointers and status
    always_ff @(posedge sys_clock) begin
        if (!sys_rst_n) begin
            r_cnt        <= '0;
            r_hi         <= '0;
            r_sum        <= '0;
            r_ovf        <= 1'b0;
            r_wr_ptr     <= '0;
            r_commit_ptr <= '0;
            r_rd_ptr     <= '0;
            r_frame_ok   <= 1'b0;
            r_frame_err  <= 1'b0;
            r_err_code   <= 2'b00;
            r_ok_cnt     <= '0;
            r_err_cnt    <= '0;
        end else begin
            r_frame_ok  <= 1'b0;
            r_frame_err <= 1'b0;
            if (w_pop) r_rd_ptr <= r_rd_ptr + PW'(1);
            case (r_state)
                LEN: begin
                    r_cnt <= (idata == 4'h0) ? CW'(16) : CW'(idata);
                    r_sum <= '0;
                    r_ovf <= 1'b0;
                end
                PAY_H, CK_H: r_hi <= idata;
                PAY_L: begin
                    r_sum <= r_sum + w_byte;
                    r_cnt <= r_cnt - CW'(1);
                    if (w_full) r_ovf    <= 1'b1;
                    else        r_wr_ptr <= r_wr_ptr + PW'(1);
                end
                CK_L: begin
                    if (w_commit) begin
                        r_commit_ptr <= r_wr_ptr;
                        r_frame_ok   <= 1'b1;
                        if (r_ok_cnt != 16'hFFFF) r_ok_cnt <= r_ok_cnt + 16'd1;
                    end else begin
                        // Rewind only the write side; reads of committed data continue
                        r_wr_ptr    <= r_commit_ptr;
                        r_frame_err <= 1'b1;
                        r_err_code  <= r_ovf ? 2'b10 : 2'b01;
                        if (r_err_cnt != 16'hFFFF) r_err_cnt <= r_err_cnt + 16'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge sys_clock) begin
        if (w_wr_en) r_mem[r_wr_ptr[AW-1:0]] <= {w_last, w_byte};
    end

    // Gate read data so nothing stale shows while the buffer is empty
    assign m_tvalid  = w_valid;
    assign m_tdata   = w_valid ? w_rd_word[7:0] : 8'h00;
    assign m_tlast   = w_valid & w_rd_word[8];
    assign frame_ok  = r_frame_ok;
    assign frame_err = r_frame_err;
    assign err_code  = r_err_code;
    assign ok_cnt    = r_ok_cnt;
    assign err_cnt   = r_err_cnt;

endmodule

// File: tb/tb_nibble_frame_rx.sv
// Directed self-checking bench for nibble_frame_rx: a vector table of short frames
// plus hand-written sequences for backpressure, overflow, sync hunting and reset.
module tb_nibble_frame_rx;

    logic        clk;
    logic        rst_n;
    logic [3:0]  idata;
    logic [7:0]  m_tdata;
    logic        m_tvalid;
    logic        m_tready;
    logic        m_tlast;
    logic        frame_ok;
    logic        frame_err;
    logic [1:0]  err_code;
    logic [15:0] ok_cnt;
    logic [15:0] err_cnt;

    nibble_frame_rx #(.DEPTH(32)) dut (
        .sys_clock (clk),
        .sys_rst_n (rst_n),
        .idata     (idata),
        .m_tdata   (m_tdata),
        .m_tvalid  (m_tvalid),
        .m_tready  (m_tready),
        .m_tlast   (m_tlast),
        .frame_ok  (frame_ok),
        .frame_err (frame_err),
        .err_code  (err_code),
        .ok_cnt    (ok_cnt),
        .err_cnt   (err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [47:0] nibs;   // first nibble in the top 4 bits
        int          n;
        logic        ok;
        logic        err;
        logic [1:0]  code;
        int          nb;
        logic [7:0]  b0, b1, b2;
    } vec_t;

    vec_t       vecs[7];
    int         n_chk = 0;
    int         n_err = 0;
    int         p_ok  = 0;
    int         p_err = 0;
    int         exp_okc = 0;
    int         exp_errc = 0;
    logic [1:0] exp_code = 2'b00;
    logic [8:0] exp_q[$];
    logic [8:0] got_q[$];
    logic       mon_en = 1'b0;

    always @(posedge clk) begin
        if (frame_ok)  p_ok  <= p_ok + 1;
        if (frame_err) p_err <= p_err + 1;
        if (mon_en && m_tvalid && m_tready) got_q.push_back({m_tlast, m_tdata});
    end

    task automatic chk(input string name, input logic [47:0] act, input logic [47:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic send_nib(input logic [3:0] n);
        idata = n;
        @(posedge clk); #1;
    endtask

    task automatic check_zero(input string name);
        chk(name, 48'({m_tvalid, m_tdata, m_tlast, frame_ok, frame_err, err_code, ok_cnt, err_cnt}), 48'h0);
    endtask

    task automatic do_reset(input string name);
        rst_n = 1'b0;
        @(posedge clk); #1;
        check_zero(name);
        rst_n    = 1'b1;
        exp_okc  = 0;
        exp_errc = 0;
        exp_code = 2'b00;
        exp_q.delete();
    endtask

    task automatic check_status(input string name, input logic ok, input logic err);
        chk({name, "_ok"},   48'(frame_ok), 48'(ok));
        chk({name, "_err"},  48'(frame_err), 48'(err));
        chk({name, "_code"}, 48'(err_code), 48'(exp_code));
        chk({name, "_cnt"},  48'({ok_cnt, err_cnt}), 48'({16'(exp_okc), 16'(exp_errc)}));
        if (!m_tready) chk({name, "_valid"}, 48'(m_tvalid), 48'(exp_q.size() != 0));
    endtask

    // Sends one frame of len bytes base, base+1, ...; code 0 means commit is expected
    task automatic send_frame(input string name, input int len, input logic [7:0] base,
                              input logic corrupt, input logic [1:0] code);
        logic [7:0] sum;
        logic [7:0] b;
        logic [7:0] ck;
        logic [7:0] bs[16];
        sum = 8'h00;
        send_nib(4'hA);
        send_nib(4'h5);
        send_nib(4'(len));
        for (int k = 0; k < len; k++) begin
            b     = base + 8'(k);
            bs[k] = b;
            sum   = sum + b;
            send_nib(b[7:4]);
            send_nib(b[3:0]);
        end
        ck = corrupt ? (sum ^ 8'h01) : sum;
        send_nib(ck[7:4]);
        send_nib(ck[3:0]);
        if (code == 2'b00) begin
            exp_okc++;
            for (int k = 0; k < len; k++) exp_q.push_back({k == len - 1, bs[k]});
        end else begin
            exp_errc++;
            exp_code = code;
        end
        check_status(name, code == 2'b00, code != 2'b00);
    endtask

    task automatic drain_all(input string name);
        logic [8:0] e;
        m_tready = 1'b1;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk({name, "_dvalid"}, 48'(m_tvalid), 48'h1);
            chk({name, "_dbeat"},  48'({m_tlast, m_tdata}), 48'(e));
            @(posedge clk); #1;
        end
        m_tready = 1'b0;
        chk({name, "_empty"}, 48'(m_tvalid), 48'h0);
    endtask

    initial begin
        int ok0;
        int err0;
        vecs[0] = '{"bad_ck",  48'hA53123456570, 11, 1'b0, 1'b1, 2'b01, 0, 8'h00, 8'h00, 8'h00};
        vecs[1] = '{"good3",   48'hA531234569C0, 11, 1'b1, 1'b0, 2'b00, 3, 8'h12, 8'h34, 8'h56};
        vecs[2] = '{"a5_data", 48'hA51A5A500000,  7, 1'b1, 1'b0, 2'b00, 1, 8'hA5, 8'h00, 8'h00};
        vecs[3] = '{"sumwrap", 48'hA52FF0201000,  9, 1'b1, 1'b0, 2'b00, 2, 8'hFF, 8'h02, 8'h00};
        vecs[4] = '{"no_sync", 48'hA35000000000,  6, 1'b0, 1'b0, 2'b00, 0, 8'h00, 8'h00, 8'h00};
        vecs[5] = '{"bad2",    48'hA52112200000,  9, 1'b0, 1'b1, 2'b01, 0, 8'h00, 8'h00, 8'h00};
        vecs[6] = '{"resync",  48'hAA5177770000,  8, 1'b1, 1'b0, 2'b00, 1, 8'h77, 8'h00, 8'h00};

        rst_n    = 1'b0;
        idata    = 4'h0;
        m_tready = 1'b0;
        @(posedge clk); #1;
        do_reset("reset");

        // Table of short frames, each drained after its status is checked
        for (int v = 0; v < 7; v++) begin
            ok0  = p_ok;
            err0 = p_err;
            for (int i = 0; i < vecs[v].n; i++) send_nib(vecs[v].nibs[47 - 4*i -: 4]);
            if (vecs[v].ok)  exp_okc++;
            if (vecs[v].err) begin
                exp_errc++;
                exp_code = vecs[v].code;
            end
            if (vecs[v].nb > 0) exp_q.push_back({vecs[v].nb == 1, vecs[v].b0});
            if (vecs[v].nb > 1) exp_q.push_back({vecs[v].nb == 2, vecs[v].b1});
            if (vecs[v].nb > 2) exp_q.push_back({1'b1, vecs[v].b2});
            check_status(vecs[v].name, vecs[v].ok, vecs[v].err);
            send_nib(4'h0);
            chk({vecs[v].name, "_pulses"}, 48'({16'(p_ok - ok0), 16'(p_err - err0)}),
                48'({16'(vecs[v].ok), 16'(vecs[v].err)}));
            drain_all(vecs[v].name);
        end

        // Backpressure: data held steady, then three consecutive beats
        send_frame("bp", 3, 8'h21, 1'b0, 2'b00);
        for (int c = 0; c < 10; c++) begin
            chk("bp_hold", 48'({m_tvalid, m_tlast, m_tdata}), 48'({1'b1, 1'b0, 8'h21}));
            send_nib(4'h0);
        end
        drain_all("bp");

        // Overflow: two full frames fill the buffer, third is discarded
        send_frame("ovf1", 16, 8'h00, 1'b0, 2'b00);
        send_frame("ovf2", 16, 8'h10, 1'b0, 2'b00);
        send_frame("ovf3", 16, 8'h20, 1'b0, 2'b10);
        drain_all("ovf");

        // Sync hunting: 0 A A 5 0 ... accepted as a 16-byte frame
        send_nib(4'h0);
        send_nib(4'hA);
        send_frame("hunt", 16, 8'hC0, 1'b0, 2'b00);
        drain_all("hunt");

        // Back-to-back good / corrupt / good with the sink always ready
        got_q.delete();
        mon_en   = 1'b1;
        m_tready = 1'b1;
        send_frame("mid1", 2, 8'h40, 1'b0, 2'b00);
        send_frame("mid2", 2, 8'h50, 1'b1, 2'b01);
        send_frame("mid3", 3, 8'h60, 1'b0, 2'b00);
        for (int c = 0; c < 8; c++) send_nib(4'h0);
        mon_en   = 1'b0;
        m_tready = 1'b0;
        chk("mid_count", 48'(got_q.size()), 48'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            chk("mid_beat", 48'(got_q[i]), 48'(exp_q[i]));
        exp_q.delete();
        chk("mid_empty", 48'(m_tvalid), 48'h0);

        // Reset inside PAY_L, then reset with committed unread data
        send_nib(4'hA);
        send_nib(4'h5);
        send_nib(4'h3);
        send_nib(4'h1);
        idata = 4'h2;
        do_reset("rst_payl");
        send_frame("pre_rst", 3, 8'h70, 1'b0, 2'b00);
        do_reset("rst_data");
        send_frame("post_rst", 2, 8'h80, 1'b0, 2'b00);
        drain_all("post_rst");

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, errors=%0d", n_err);
        $fatal(1);
    end

endmodule
